// File: rtl/config_sequencer.sv
// Power-up configuration sequencer: streams a fixed ROM table to a peripheral
// writer over valid/ready, with a settle gap between words and a handshake timeout.
module config_sequencer #(
  parameter int NUM_WORDS      = 8,
  parameter int ADDR_W         = 3,
  parameter int DATA_W         = 24,
  parameter int WAIT_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_config,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              busy,
  output logic              config_done,
  output logic              config_error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_SEND  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [31:0]       GAP_LAST  = (WAIT_CYCLES > 0) ? 32'(WAIT_CYCLES - 1) : 32'd0;
  localparam logic [31:0]       TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state;
  logic [31:0] cnt;
  logic        start_q;
  logic        can_start;
  logic        last_word;

  assign can_start = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign last_word = (rom_addr == LAST_ADDR);

  // The start pulse is registered once and only accepted when no sequence is
  // running, so the first FETCH appears one edge after the pulse is sampled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      start_q  <= 1'b0;
      rom_addr <= '0;
      wr_data  <= '0;
    end else begin
      start_q <= start_config && can_start;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_q) begin
            state    <= S_FETCH;
            rom_addr <= '0;
          end
        end
        S_FETCH: state <= S_READ;
        S_READ: begin
          wr_data <= rom_data;
          cnt     <= '0;
          state   <= S_SEND;
        end
        S_SEND: begin
          // A transfer on the expiry edge takes priority over the timeout.
          if (wr_ready) begin
            cnt <= '0;
            if (WAIT_CYCLES > 0) begin
              state <= S_GAP;
            end else if (last_word) begin
              state <= S_DONE;
            end else begin
              state    <= S_FETCH;
              rom_addr <= rom_addr + ADDR_ONE;
            end
          end else if (cnt == TO_LAST) begin
            state <= S_ERROR;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            if (last_word) begin
              state <= S_DONE;
            end else begin
              state    <= S_FETCH;
              rom_addr <= rom_addr + ADDR_ONE;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign wr_valid     = (state == S_SEND);
  assign busy         = (state == S_FETCH) || (state == S_READ) ||
                        (state == S_SEND)  || (state == S_GAP);
  assign config_done  = (state == S_DONE);
  assign config_error = (state == S_ERROR);

endmodule

// File: tb/tb_config_sequencer.sv
// Bench for config_sequencer: two instances (gapped and zero-gap), registered ROM
// models, and an edge-indexed reference schedule derived from the handshake rules.
module tb_config_sequencer;
  localparam int TO = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  start_cfg, wr_ready, wr_valid, busy, cfg_done, cfg_err;
  logic [2:0]  rom_addr [2];
  logic [23:0] rom_data [2];
  logic [23:0] wr_data  [2];
  logic [23:0] rom_mem  [2][8];

  bit rdy_pat   [256];
  bit start_pat [256];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data[0] <= rom_mem[0][rom_addr[0]];
    rom_data[1] <= rom_mem[1][rom_addr[1]];
  end

  config_sequencer #(.NUM_WORDS(4), .ADDR_W(3), .DATA_W(24), .WAIT_CYCLES(2),
                     .TIMEOUT_CYCLES(TO)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start_config(start_cfg[0]),
    .rom_addr(rom_addr[0]), .rom_data(rom_data[0]), .wr_data(wr_data[0]),
    .wr_valid(wr_valid[0]), .wr_ready(wr_ready[0]), .busy(busy[0]),
    .config_done(cfg_done[0]), .config_error(cfg_err[0]));

  config_sequencer #(.NUM_WORDS(8), .ADDR_W(3), .DATA_W(24), .WAIT_CYCLES(0),
                     .TIMEOUT_CYCLES(TO)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start_config(start_cfg[1]),
    .rom_addr(rom_addr[1]), .rom_data(rom_data[1]), .wr_data(wr_data[1]),
    .wr_valid(wr_valid[1]), .wr_ready(wr_ready[1]), .busy(busy[1]),
    .config_done(cfg_done[1]), .config_error(cfg_err[1]));

  function automatic int nw(input int d);
    return (d == 0) ? 4 : 8;
  endfunction

  function automatic int wt(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic fill_rom(input int d, input bit rnd);
    for (int i = 0; i < 8; i++)
      rom_mem[d][i] = rnd ? 24'($urandom) : 24'hA00000 + 24'(i);
  endtask

  task automatic fill_ready(input int one_in);
    for (int e = 0; e < 256; e++)
      rdy_pat[e] = (one_in <= 1) ? 1'b1 : ($urandom_range(0, one_in - 1) == 0);
  endtask

  // Reference: word i becomes valid at vrise[i]; it transfers on the first edge
  // within TO edges where ready is high, else the run errors at vrise+TO. The next
  // word is valid WAIT+2 edges after a transfer; done comes WAIT edges after the last.
  task automatic run_and_check(input int d, input bit extra_starts, input string name);
    int vrise [8];
    int xend  [8];
    int nvalid, fin, t, e_x, last_e, end_e, wi;
    bit err, ev;
    logic [3:0] got, exp;
    t = 3; err = 0; nvalid = 0; last_e = 0;
    for (int i = 0; i < nw(d); i++) begin
      vrise[i] = t;
      nvalid   = i + 1;
      e_x      = -1;
      for (int k = t + 1; k <= t + TO; k++)
        if (rdy_pat[k]) begin
          e_x = k;
          break;
        end
      if (e_x < 0) begin
        err     = 1;
        xend[i] = t + TO;
        break;
      end
      xend[i] = e_x;
      last_e  = e_x;
      t       = e_x + wt(d) + 2;
    end
    fin   = err ? xend[nvalid-1] : last_e + wt(d);
    end_e = fin + 2;
    for (int e = 0; e < 256; e++) start_pat[e] = 1'b0;
    start_pat[0] = 1'b1;
    if (extra_starts)
      for (int i = 0; i < nvalid; i++) start_pat[vrise[i] + 1] = 1'b1;

    for (int e = 0; e <= end_e; e++) begin
      start_cfg[d] = start_pat[e];
      wr_ready[d]  = rdy_pat[e];
      @(posedge clk); #1;
      if (e == 0) continue;
      ev = 0; wi = 0;
      for (int i = 0; i < nvalid; i++)
        if (e >= vrise[i] && e < xend[i]) begin
          ev = 1;
          wi = i;
        end
      exp = {ev, (e < fin), (!err && e >= fin), (err && e >= fin)};
      got = {wr_valid[d], busy[d], cfg_done[d], cfg_err[d]};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s status edge %0d: valid/busy/done/err got %b expected %b", name, e, got, exp);
      end
      if (ev) begin
        n_tests++;
        if (wr_data[d] !== rom_mem[d][wi]) begin
          n_fail++;
          $display("FAIL %s wr_data edge %0d word %0d: got %h expected %h", name, e, wi,
                   wr_data[d], rom_mem[d][wi]);
        end
      end
      for (int i = 0; i < nvalid; i++)
        if (e == vrise[i] - 1) begin
          n_tests++;
          if (rom_addr[d] !== 3'(i)) begin
            n_fail++;
            $display("FAIL %s rom_addr edge %0d: got %0d expected %0d", name, e, rom_addr[d], i);
          end
        end
    end
    start_cfg[d] = 1'b0;
    wr_ready[d]  = 1'b0;
    if (!err) begin
      n_tests++;
      if (rom_addr[d] !== 3'(nw(d) - 1)) begin
        n_fail++;
        $display("FAIL %s final rom_addr: got %0d expected %0d", name, rom_addr[d], nw(d) - 1);
      end
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    start_cfg = 2'b11;
    wr_ready  = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({wr_valid[d], busy[d], cfg_done[d], cfg_err[d]} !== 4'b0 ||
          rom_addr[d] !== 3'd0 || wr_data[d] !== 24'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d: v/b/d/e=%b addr=%0d data=%h expected all zero", d,
                 {wr_valid[d], busy[d], cfg_done[d], cfg_err[d]}, rom_addr[d], wr_data[d]);
      end
    end
    reset_n   = 1'b1;
    start_cfg = 2'b00;
    wr_ready  = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({wr_valid[d], busy[d], cfg_done[d], cfg_err[d]} !== 4'b0) begin
        n_fail++;
        $display("FAIL idle dut%0d: v/b/d/e=%b expected 0000", d,
                 {wr_valid[d], busy[d], cfg_done[d], cfg_err[d]});
      end
    end
  endtask

  task automatic test_nominal();
    fill_rom(0, 1'b0);
    fill_ready(1);
    run_and_check(0, 1'b0, "nominal");
  endtask

  task automatic test_back_pressure();
    fill_rom(0, 1'b1);
    fill_ready(1);
    for (int e = 9; e <= 15; e++) rdy_pat[e] = 1'b0;
    run_and_check(0, 1'b0, "back_pressure");
  endtask

  task automatic test_timeout();
    fill_rom(0, 1'b1);
    fill_ready(0);
    for (int e = 0; e < 256; e++) rdy_pat[e] = 1'b0;
    run_and_check(0, 1'b0, "timeout");
    fill_ready(1);
    run_and_check(0, 1'b0, "restart_after_error");
  endtask

  task automatic test_zero_gap();
    fill_rom(1, 1'b1);
    fill_ready(1);
    run_and_check(1, 1'b0, "zero_gap");
  endtask

  task automatic test_mid_reset();
    fill_rom(0, 1'b1);
    start_cfg[0] = 1'b1;
    wr_ready[0]  = 1'b1;
    @(posedge clk); #1;
    start_cfg[0] = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    n_tests++;
    if ({wr_valid[0], busy[0]} !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_reset gap state: valid/busy got %b expected 01", {wr_valid[0], busy[0]});
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({wr_valid[0], busy[0], cfg_done[0], cfg_err[0]} !== 4'b0 ||
        rom_addr[0] !== 3'd0 || wr_data[0] !== 24'd0) begin
      n_fail++;
      $display("FAIL mid_reset outputs: v/b/d/e=%b addr=%0d data=%h expected all zero",
               {wr_valid[0], busy[0], cfg_done[0], cfg_err[0]}, rom_addr[0], wr_data[0]);
    end
    reset_n     = 1'b1;
    wr_ready[0] = 1'b0;
    @(posedge clk); #1;
    fill_ready(1);
    run_and_check(0, 1'b0, "after_reset");
  endtask

  task automatic test_start_busy();
    for (int d = 0; d < 2; d++) begin
      fill_rom(d, 1'b1);
      fill_ready(2);
      run_and_check(d, 1'b1, "start_busy");
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int d;
      d = it % 2;
      fill_rom(d, 1'b1);
      fill_ready((it >= 7) ? 12 : $urandom_range(1, 4));
      run_and_check(d, it[0] ^ it[1], "random");
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    start_cfg = 2'b00;
    wr_ready  = 2'b00;
    fill_rom(0, 1'b0);
    fill_rom(1, 1'b0);
    @(posedge clk); #1;
    test_reset();
    test_nominal();
    test_back_pressure();
    test_timeout();
    test_zero_gap();
    test_mid_reset();
    test_start_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
